// File: rtl/mcast_branch_seq.sv
// mcast_branch_seq
// Sequential multicast branch generator for an XY-tree router. One head
// descriptor (unicast id or multicast bitmap) is accepted at a time. Its
// destinations are split by output port, and one branch per non-empty port is
// emitted in ascending port-code order under valid/ready flow control.
module mcast_branch_seq #(
  parameter  int MESH_X  = 4,
  parameter  int MESH_Y  = 4,
  parameter  int MY_XPOS = 0,
  parameter  int MY_YPOS = 0,
  localparam int N_NODES = MESH_X * MESH_Y,
  localparam int ID_W    = $clog2(N_NODES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_um_type,
  input  logic [ID_W-1:0]    in_uni_dst,
  input  logic [N_NODES-1:0] in_mult_dst,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_port,
  output logic [N_NODES-1:0] out_dst_mask,
  output logic               out_last,
  output logic               busy,
  output logic               err_pulse
);

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_EAST  = 3'd1;
  localparam logic [2:0] P_WEST  = 3'd2;
  localparam logic [2:0] P_NORTH = 3'd3;
  localparam logic [2:0] P_SOUTH = 3'd4;

  // Elaboration-time bitmap of every node routed through port p
  // (node id = x*MESH_Y + y).
  function automatic logic [N_NODES-1:0] class_mask(input logic [2:0] p);
    logic [N_NODES-1:0] m;
    int x;
    int y;
    logic [2:0] c;
    m = '0;
    for (int i = 0; i < N_NODES; i++) begin
      x = i / MESH_Y;
      y = i % MESH_Y;
      if (x > MY_XPOS)      c = P_EAST;
      else if (x < MY_XPOS) c = P_WEST;
      else if (y > MY_YPOS) c = P_NORTH;
      else if (y < MY_YPOS) c = P_SOUTH;
      else                  c = P_LOCAL;
      if (c == p) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [N_NODES-1:0] MASK_LOCAL = class_mask(P_LOCAL);
  localparam logic [N_NODES-1:0] MASK_EAST  = class_mask(P_EAST);
  localparam logic [N_NODES-1:0] MASK_WEST  = class_mask(P_WEST);
  localparam logic [N_NODES-1:0] MASK_NORTH = class_mask(P_NORTH);
  localparam logic [N_NODES-1:0] MASK_SOUTH = class_mask(P_SOUTH);

  // Lowest port code that still has a destination in m.
  function automatic logic [2:0] pick_port(input logic [N_NODES-1:0] m);
    if (|(m & MASK_LOCAL))      return P_LOCAL;
    else if (|(m & MASK_EAST))  return P_EAST;
    else if (|(m & MASK_WEST))  return P_WEST;
    else if (|(m & MASK_NORTH)) return P_NORTH;
    else                        return P_SOUTH;
  endfunction

  function automatic logic [N_NODES-1:0] port_mask(input logic [2:0] p);
    case (p)
      P_LOCAL: return MASK_LOCAL;
      P_EAST:  return MASK_EAST;
      P_WEST:  return MASK_WEST;
      P_NORTH: return MASK_NORTH;
      P_SOUTH: return MASK_SOUTH;
      default: return '0;
    endcase
  endfunction

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_q, state_d;
  logic [N_NODES-1:0] rem_q, rem_d;
  logic [2:0]         port_d;
  logic [N_NODES-1:0] dst_d;
  logic               last_d;
  logic               err_d;

  logic               accept;
  logic               handshake;
  logic               uni_in_range;
  logic [N_NODES-1:0] load_mask;
  logic [N_NODES-1:0] rem_after;
  logic [N_NODES-1:0] src_mask;
  logic [2:0]         nxt_port;
  logic [N_NODES-1:0] nxt_dst;
  logic               nxt_last;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == EMIT);
  assign out_valid = (state_q == EMIT);
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  // Decode the incoming descriptor and precompute the next branch to present:
  // from the fresh descriptor in IDLE, from what is left after this branch in EMIT.
  always_comb begin
    uni_in_range = ({1'b0, in_uni_dst} < (ID_W + 1)'(N_NODES));
    load_mask    = '0;
    if (in_um_type)        load_mask = in_mult_dst;
    else if (uni_in_range) load_mask = N_NODES'(1) << in_uni_dst;
    rem_after = rem_q & ~out_dst_mask;
    src_mask  = (state_q == IDLE) ? load_mask : rem_after;
    nxt_port  = pick_port(src_mask);
    nxt_dst   = src_mask & port_mask(nxt_port);
    nxt_last  = ~|(src_mask & ~nxt_dst);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: empty descriptors never leave IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && |load_mask) state_d = EMIT;
      EMIT:    if (handshake && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; they only move on accept or handshake,
  // so a stalled branch holds steady.
  always_comb begin
    rem_d  = rem_q;
    port_d = out_port;
    dst_d  = out_dst_mask;
    last_d = out_last;
    err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (|load_mask) begin
            rem_d  = load_mask;
            port_d = nxt_port;
            dst_d  = nxt_dst;
            last_d = nxt_last;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (handshake) begin
          if (out_last) begin
            rem_d  = '0;
            port_d = P_LOCAL;
            dst_d  = '0;
            last_d = 1'b0;
          end else begin
            rem_d  = rem_after;
            port_d = nxt_port;
            dst_d  = nxt_dst;
            last_d = nxt_last;
          end
        end
      end
      default: ;
    endcase
  end

  // Remaining-mask and branch output registers; reset clears any descriptor in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q        <= '0;
      out_port     <= P_LOCAL;
      out_dst_mask <= '0;
      out_last     <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      rem_q        <= rem_d;
      out_port     <= port_d;
      out_dst_mask <= dst_d;
      out_last     <= last_d;
      err_pulse    <= err_d;
    end
  end

endmodule

// File: tb/tb_mcast_branch_seq.sv
// Directed bench for mcast_branch_seq: 4x4 router at (1,0), 8x8 router at (3,4),
// and 4x5 router at (0,1) for out-of-range unicast ids.
module tb_mcast_branch_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic out_rdy;
  int   total = 0;
  int   bad   = 0;
  int   sel   = 0;

  // 4x4 @ (1,0)
  logic        a_in_valid, a_in_ready, a_um, a_out_valid, a_last, a_busy, a_err;
  logic [3:0]  a_uni;
  logic [15:0] a_mult, a_mask;
  logic [2:0]  a_port;
  // 8x8 @ (3,4)
  logic        b_in_valid, b_in_ready, b_um, b_out_valid, b_last, b_busy, b_err;
  logic [5:0]  b_uni;
  logic [63:0] b_mult, b_mask;
  logic [2:0]  b_port;
  // 4x5 @ (0,1)
  logic        c_in_valid, c_in_ready, c_um, c_out_valid, c_last, c_busy, c_err;
  logic [4:0]  c_uni;
  logic [19:0] c_mult, c_mask;
  logic [2:0]  c_port;

  mcast_branch_seq #(.MESH_X(4), .MESH_Y(4), .MY_XPOS(1), .MY_YPOS(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_um_type(a_um), .in_uni_dst(a_uni), .in_mult_dst(a_mult),
    .out_valid(a_out_valid), .out_ready(out_rdy), .out_port(a_port),
    .out_dst_mask(a_mask), .out_last(a_last), .busy(a_busy), .err_pulse(a_err));

  mcast_branch_seq #(.MESH_X(8), .MESH_Y(8), .MY_XPOS(3), .MY_YPOS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_um_type(b_um), .in_uni_dst(b_uni), .in_mult_dst(b_mult),
    .out_valid(b_out_valid), .out_ready(out_rdy), .out_port(b_port),
    .out_dst_mask(b_mask), .out_last(b_last), .busy(b_busy), .err_pulse(b_err));

  mcast_branch_seq #(.MESH_X(4), .MESH_Y(5), .MY_XPOS(0), .MY_YPOS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_um_type(c_um), .in_uni_dst(c_uni), .in_mult_dst(c_mult),
    .out_valid(c_out_valid), .out_ready(out_rdy), .out_port(c_port),
    .out_dst_mask(c_mask), .out_last(c_last), .busy(c_busy), .err_pulse(c_err));

  // Outputs of the instance under test.
  logic        m_valid, m_last, m_rdy, m_busy, m_err;
  logic [2:0]  m_port;
  logic [63:0] m_mask;
  always_comb begin
    case (sel)
      0: begin m_valid = a_out_valid; m_last = b_last & 1'b0 | a_last; m_port = a_port;
               m_mask = 64'(a_mask); m_rdy = a_in_ready; m_busy = a_busy; m_err = a_err; end
      1: begin m_valid = b_out_valid; m_last = b_last; m_port = b_port;
               m_mask = b_mask; m_rdy = b_in_ready; m_busy = b_busy; m_err = b_err; end
      default: begin m_valid = c_out_valid; m_last = c_last; m_port = c_port;
               m_mask = 64'(c_mask); m_rdy = c_in_ready; m_busy = c_busy; m_err = c_err; end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_br(input string tag, input logic [2:0] port, input logic [63:0] mask,
                        input logic last);
    chk({tag, "/valid"}, 64'(m_valid), 64'd1);
    chk({tag, "/port"},  64'(m_port),  64'(port));
    chk({tag, "/mask"},  m_mask,       mask);
    chk({tag, "/last"},  64'(m_last),  64'(last));
  endtask

  // Expect a branch, hold out_ready low for 'stall' cycles first, then consume it.
  task automatic branch(input string tag, input logic [2:0] port, input logic [63:0] mask,
                        input logic last, input int stall);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk_br({tag, "/stall"}, port, mask, last);
    end
    @(negedge clk);
    chk_br(tag, port, mask, last);
    out_rdy = 1'b1;
    @(posedge clk);
    #1 out_rdy = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, "/in_ready"},  64'(m_rdy),   64'd1);
    chk({tag, "/out_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "/busy"},      64'(m_busy),  64'd0);
  endtask

  task automatic send_a(input logic um, input logic [3:0] uni, input logic [15:0] mult);
    @(negedge clk);
    a_um = um; a_uni = uni; a_mult = mult; a_in_valid = 1'b1;
    @(posedge clk);
    #1 a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic um, input logic [5:0] uni, input logic [63:0] mult);
    @(negedge clk);
    b_um = um; b_uni = uni; b_mult = mult; b_in_valid = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
  endtask

  task automatic send_c(input logic um, input logic [4:0] uni, input logic [19:0] mult);
    @(negedge clk);
    c_um = um; c_uni = uni; c_mult = mult; c_in_valid = 1'b1;
    @(posedge clk);
    #1 c_in_valid = 1'b0;
  endtask

  task automatic chk_drop(input string tag);
    @(negedge clk);
    chk({tag, "/err"},       64'(m_err),   64'd1);
    chk({tag, "/out_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "/in_ready"},  64'(m_rdy),   64'd1);
    @(negedge clk);
    chk({tag, "/err_clr"},   64'(m_err),   64'd0);
    chk({tag, "/no_valid"},  64'(m_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; out_rdy = 1'b0;
    a_in_valid = 0; a_um = 0; a_uni = '0; a_mult = '0;
    b_in_valid = 0; b_um = 0; b_uni = '0; b_mult = '0;
    c_in_valid = 0; c_um = 0; c_uni = '0; c_mult = '0;
    repeat (2) @(negedge clk);
    chk("rst/in_ready",  64'(a_in_ready),  64'd1);
    chk("rst/out_valid", 64'(a_out_valid), 64'd0);
    chk("rst/busy",      64'(a_busy),      64'd0);
    chk("rst/err",       64'(a_err),       64'd0);
    chk("rst/port",      64'(a_port),      64'd0);
    chk("rst/mask",      64'(a_mask),      64'd0);
    chk("rst/last",      64'(a_last),      64'd0);
    rst_n = 1'b1;

    // Multicast 0x2252 through router (1,0)
    sel = 0;
    send_a(1'b1, 4'd0, 16'h2252);
    chk("t1/busy",     64'(a_busy),     64'd1);
    chk("t1/in_ready", 64'(a_in_ready), 64'd0);
    branch("t1/local", 3'd0, 64'h0010, 1'b0, 0);
    branch("t1/east",  3'd1, 64'h2200, 1'b0, 0);
    branch("t1/west",  3'd2, 64'h0002, 1'b0, 0);
    branch("t1/north", 3'd3, 64'h0040, 1'b1, 0);
    chk_idle("t1/end");

    // Unicast to node 7 = (1,3)
    send_a(1'b0, 4'd7, 16'h0000);
    branch("t2/north", 3'd3, 64'h0080, 1'b1, 0);
    chk_idle("t2/end");

    // Same multicast with a 3-cycle stall on each branch
    send_a(1'b1, 4'd0, 16'h2252);
    branch("t3/local", 3'd0, 64'h0010, 1'b0, 3);
    branch("t3/east",  3'd1, 64'h2200, 1'b0, 3);
    branch("t3/west",  3'd2, 64'h0002, 1'b0, 3);
    branch("t3/north", 3'd3, 64'h0040, 1'b1, 3);
    chk_idle("t3/end");

    // Empty multicast is dropped
    send_a(1'b1, 4'd0, 16'h0000);
    chk_drop("t4/empty");

    // 4x5 router (0,1): id 25 is outside the 20-node mesh, id 16 = (3,1) goes east
    sel = 2;
    send_c(1'b0, 5'd25, 20'h0);
    chk_drop("t4/range");
    send_c(1'b0, 5'd16, 20'h0);
    branch("t4/uni16", 3'd1, 64'h10000, 1'b1, 0);
    chk_idle("t4/end");

    // Reset during the second branch
    sel = 0;
    send_a(1'b1, 4'd0, 16'h2252);
    branch("t5/local", 3'd0, 64'h0010, 1'b0, 0);
    @(negedge clk);
    chk_br("t5/east", 3'd1, 64'h2200, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5/rst_valid", 64'(a_out_valid), 64'd0);
    chk("t5/rst_port",  64'(a_port),      64'd0);
    chk("t5/rst_mask",  64'(a_mask),      64'd0);
    chk("t5/rst_rdy",   64'(a_in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("t5/after1");
    chk_idle("t5/after2");
    send_a(1'b0, 4'd4, 16'h0000);
    branch("t5/uni4", 3'd0, 64'h0010, 1'b1, 0);
    chk_idle("t5/end");

    // 8x8 router (3,4), bits 28 (local), 60 (east), 27 (south)
    sel = 1;
    send_b(1'b1, 6'd0, (64'd1 << 28) | (64'd1 << 27) | (64'd1 << 60));
    branch("t6/local", 3'd0, 64'd1 << 28, 1'b0, 0);
    branch("t6/east",  3'd1, 64'd1 << 60, 1'b0, 0);
    branch("t6/south", 3'd4, 64'd1 << 27, 1'b1, 0);
    chk_idle("t6/end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
